ktop_xfer_scheduler: RTL and testbench

KTOP_XFER_SCHEDULER -- requirements
Module: ktop_xfer_scheduler

---
 rtl/ktop_xfer_scheduler_if.sv | 33 +++
 rtl/ktop_xfer_scheduler.sv | 94 +++++++++
 tb/tb_ktop_xfer_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ktop_xfer_scheduler_if.sv
// Bundle of control-side and read/write-master handshake signals for the transfer scheduler.
// The master modport is the scheduler's view; slave is the surrounding host/master side.
interface ktop_xfer_scheduler_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32
);
  logic                          ap_start;
  logic                          ap_idle;
  logic                          ap_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
  logic                          rd_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  rd_xfer_size;
  logic                          rd_done;
  logic                          wr_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  wr_xfer_size;
  logic                          wr_done;
  logic [C_XFER_SIZE_WIDTH-1:0]  chunk_count;

  modport master (
    input  ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, rd_done, wr_done,
    output ap_idle, ap_done, rd_start, rd_addr_offset, rd_xfer_size,
           wr_start, wr_addr_offset, wr_xfer_size, chunk_count
  );

  modport slave (
    output ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, rd_done, wr_done,
    input  ap_idle, ap_done, rd_start, rd_addr_offset, rd_xfer_size,
           wr_start, wr_addr_offset, wr_xfer_size, chunk_count
  );
endinterface

// File: rtl/ktop_xfer_scheduler.sv
// Splits one host transfer into chunk-sized jobs issued in lockstep to a read and a write master,
// advancing to the next chunk only after both masters have reported completion.
module ktop_xfer_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 4096
) (
  input logic                  aclk,
  input logic                  areset,
  ktop_xfer_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [C_XFER_SIZE_WIDTH-1:0] ChunkBytes = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

  state_t                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] curAddr_q, curAddr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  remaining_q, remaining_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  chunkCount_q, chunkCount_d;
  logic                          rdSeen_q, rdSeen_d;
  logic                          wrSeen_q, wrSeen_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  chunkSize;
  logic                          bothDone;

  // The last chunk carries the exact remainder rather than a full chunk.
  assign chunkSize = (remaining_q < ChunkBytes) ? remaining_q : ChunkBytes;
  assign bothDone  = (rdSeen_q | bus.rd_done) & (wrSeen_q | bus.wr_done);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      curAddr_q    <= '0;
      remaining_q  <= '0;
      chunkCount_q <= '0;
      rdSeen_q     <= 1'b0;
      wrSeen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      curAddr_q    <= curAddr_d;
      remaining_q  <= remaining_d;
      chunkCount_q <= chunkCount_d;
      rdSeen_q     <= rdSeen_d;
      wrSeen_q     <= wrSeen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    curAddr_d    = curAddr_q;
    remaining_d  = remaining_q;
    chunkCount_d = chunkCount_q;
    rdSeen_d     = rdSeen_q;
    wrSeen_d     = wrSeen_q;
    case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          curAddr_d    = bus.ctrl_addr_offset;
          remaining_d  = bus.ctrl_xfer_size_in_bytes;
          chunkCount_d = '0;
          state_d      = (bus.ctrl_xfer_size_in_bytes == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rdSeen_d = 1'b0;
        wrSeen_d = 1'b0;
        state_d  = WAIT;
      end
      WAIT: begin
        rdSeen_d = rdSeen_q | bus.rd_done;
        wrSeen_d = wrSeen_q | bus.wr_done;
        if (bothDone) begin
          curAddr_d    = curAddr_q + C_M_AXI_ADDR_WIDTH'(chunkSize);
          remaining_d  = remaining_q - chunkSize;
          chunkCount_d = chunkCount_q + C_XFER_SIZE_WIDTH'(1);
          state_d      = (remaining_q == chunkSize) ? DONE : ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ap_idle        = (state_q == IDLE);
  assign bus.ap_done        = (state_q == DONE);
  assign bus.rd_start       = (state_q == ISSUE);
  assign bus.wr_start       = (state_q == ISSUE);
  assign bus.rd_addr_offset = curAddr_q;
  assign bus.wr_addr_offset = curAddr_q;
  assign bus.rd_xfer_size   = chunkSize;
  assign bus.wr_xfer_size   = chunkSize;
  assign bus.chunk_count    = chunkCount_q;

endmodule

// File: tb/tb_ktop_xfer_scheduler.sv
// Randomized self-checking bench: a chunk-list model built from base/size predicts every
// start pulse, address, size, completion and chunk count while the bench plays both masters.
module tb_ktop_xfer_scheduler;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  ktop_xfer_scheduler_if #(.C_M_AXI_ADDR_WIDTH(64), .C_XFER_SIZE_WIDTH(32)) bus ();

  ktop_xfer_scheduler #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH (32),
    .C_CHUNK_BYTES     (4096)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus.master)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_idle"},  64'(bus.ap_idle), 64'd1);
    checkOutput({tag, "_done"},  64'(bus.ap_done), 64'd0);
    checkOutput({tag, "_rdst"},  64'(bus.rd_start), 64'd0);
    checkOutput({tag, "_wrst"},  64'(bus.wr_start), 64'd0);
    checkOutput({tag, "_rdaddr"}, bus.rd_addr_offset, 64'd0);
    checkOutput({tag, "_wraddr"}, bus.wr_addr_offset, 64'd0);
    checkOutput({tag, "_rdsz"},  64'(bus.rd_xfer_size), 64'd0);
    checkOutput({tag, "_wrsz"},  64'(bus.wr_xfer_size), 64'd0);
    checkOutput({tag, "_count"}, 64'(bus.chunk_count), 64'd0);
  endtask

  // Caller is 1 time unit after a rising edge with the DUT in IDLE.
  // mode: 0 random, 1 wr first, 2 same cycle, 3 rd first, 4 both after 10 cycles.
  task automatic applyStimulus(input logic [63:0] base, input logic [31:0] size,
                               input int mode, input bit holdStart);
    logic [63:0] qa[$];
    logic [31:0] qs[$];
    logic [63:0] a, ea;
    logic [31:0] rem, sz, es;
    int nChunks, chunksDone, rdLeft, wrLeft, d;
    bit expIssue, expDone, inWait, finished;

    a = base; rem = size;
    while (rem != 0) begin
      sz = (rem > 32'd4096) ? 32'd4096 : rem;
      qa.push_back(a); qs.push_back(sz);
      a = a + 64'(sz); rem = rem - sz;
    end
    nChunks = qa.size();
    chunksDone = 0; rdLeft = 0; wrLeft = 0; ea = '0; es = '0;

    checkOutput("idle_before_start", 64'(bus.ap_idle), 64'd1);
    bus.ap_start = 1'b1;
    bus.ctrl_addr_offset = base;
    bus.ctrl_xfer_size_in_bytes = size;
    expIssue = (size != 0); expDone = (size == 0); inWait = 0; finished = 0;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge aclk); #1;
      bus.ctrl_addr_offset = {$urandom, $urandom};
      bus.ctrl_xfer_size_in_bytes = $urandom;
      bus.ap_start = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
      checkOutput("rd_start", 64'(bus.rd_start), 64'(expIssue));
      checkOutput("wr_start", 64'(bus.wr_start), 64'(expIssue));
      checkOutput("ap_done", 64'(bus.ap_done), 64'(expDone));
      checkOutput("ap_idle_busy", 64'(bus.ap_idle), 64'd0);
      bus.rd_done = 1'b0;
      bus.wr_done = 1'b0;
      if (expIssue) begin
        ea = qa.pop_front(); es = qs.pop_front();
        checkOutput("rd_addr", bus.rd_addr_offset, ea);
        checkOutput("wr_addr", bus.wr_addr_offset, ea);
        checkOutput("rd_size", 64'(bus.rd_xfer_size), 64'(es));
        checkOutput("wr_size", 64'(bus.wr_xfer_size), 64'(es));
        d = $urandom_range(1, 5);
        case (mode)
          1: begin wrLeft = d; rdLeft = d + $urandom_range(1, 5); end
          2: begin wrLeft = d; rdLeft = d; end
          3: begin rdLeft = d; wrLeft = d + $urandom_range(1, 5); end
          4: begin rdLeft = 10; wrLeft = 10; end
          default: begin rdLeft = $urandom_range(1, 10); wrLeft = $urandom_range(1, 10); end
        endcase
        bus.rd_done = 1'($urandom_range(0, 1));
        bus.wr_done = 1'($urandom_range(0, 1));
        expIssue = 0; inWait = 1;
      end else if (expDone) begin
        checkOutput("final_chunk_count", 64'(bus.chunk_count), 64'(nChunks));
        finished = 1;
      end else if (inWait) begin
        checkOutput("wait_addr", bus.rd_addr_offset, ea);
        checkOutput("wait_size", 64'(bus.wr_xfer_size), 64'(es));
        checkOutput("wait_count", 64'(bus.chunk_count), 64'(chunksDone));
        if (rdLeft > 0) begin rdLeft--; if (rdLeft == 0) bus.rd_done = 1'b1; end
        if (wrLeft > 0) begin wrLeft--; if (wrLeft == 0) bus.wr_done = 1'b1; end
        if (rdLeft == 0 && wrLeft == 0) begin
          inWait = 0; chunksDone++;
          if (qa.size() != 0) expIssue = 1; else expDone = 1;
        end
      end
    end
    if (!finished) checkOutput("run_timeout", 64'd0, 64'd1);

    bus.ap_start = holdStart;
    @(posedge aclk); #1;
    checkOutput("idle_after_done", 64'(bus.ap_idle), 64'd1);
    checkOutput("done_one_cycle", 64'(bus.ap_done), 64'd0);
    checkOutput("idle_no_start", 64'(bus.rd_start), 64'd0);
    // Stray dones while idle must be ignored.
    bus.rd_done = 1'($urandom_range(0, 1));
    bus.wr_done = 1'($urandom_range(0, 1));
  endtask

  initial begin
    areset = 1'b1;
    bus.ap_start = 1'b0;
    bus.rd_done = 1'b0;
    bus.wr_done = 1'b0;
    bus.ctrl_addr_offset = '0;
    bus.ctrl_xfer_size_in_bytes = '0;
    #1;
    checkResetOutputs("reset");
    @(posedge aclk); @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;

    applyStimulus(64'h1000, 32'd8192, 4, 1'b0);
    applyStimulus(64'h2_0000, 32'd4100, 0, 1'b0);
    applyStimulus(64'h3_0000, 32'd0, 0, 1'b0);
    applyStimulus(64'h4_0000, 32'd12288, 1, 1'b0);
    applyStimulus(64'h5_0000, 32'd12288, 2, 1'b0);
    applyStimulus(64'h6_0000, 32'd12288, 3, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_F000, 32'd8192, 0, 1'b0);
    applyStimulus(64'h7_0000, 32'd5000, 0, 1'b1);
    applyStimulus(64'h8_0000, 32'd100, 0, 1'b0);

    // Reset during WAIT of the first of three chunks.
    bus.rd_done = 1'b0; bus.wr_done = 1'b0;
    bus.ap_start = 1'b1;
    bus.ctrl_addr_offset = 64'h9_0000;
    bus.ctrl_xfer_size_in_bytes = 32'd12288;
    @(posedge aclk); #1;
    bus.ap_start = 1'b0;
    checkOutput("rst_run_issue", 64'(bus.rd_start), 64'd1);
    @(posedge aclk); #2;
    areset = 1'b1;
    #1;
    checkResetOutputs("midrun_reset");
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      checkOutput("post_reset_no_done", 64'(bus.ap_done), 64'd0);
      checkOutput("post_reset_idle", 64'(bus.ap_idle), 64'd1);
    end
    applyStimulus(64'hA_0000, 32'd4096, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      applyStimulus({$urandom, $urandom}, 32'($urandom_range(0, 20000)), 0, 1'($urandom_range(0, 1)));
    end
    bus.ap_start = 1'b0;
    @(posedge aclk); #1;
    // A held start may have launched one more run; let it drain.
    for (int i = 0; i < 400 && !bus.ap_idle; i++) begin
      bus.rd_done = 1'b1; bus.wr_done = 1'b1;
      @(posedge aclk); #1;
    end
    checkOutput("final_idle", 64'(bus.ap_idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
